// File: rtl/play_i2s_tx.sv
// rtl/play_i2s_tx.sv - I2S / left-justified DAC serializer with a one-pair holding buffer and underrun counting.
// All state advances on the falling i_bclk edge so o_dacdat is stable for the codec's rising-edge sample.
module play_i2s_tx #(
  parameter int SAMPLE_W = 16,
  parameter int UCNT_W   = 8
) (
  input  logic                i_bclk,
  input  logic                i_rst_n,
  input  logic                i_daclrck,
  input  logic                i_mode,
  input  logic [SAMPLE_W-1:0] i_left,
  input  logic [SAMPLE_W-1:0] i_right,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_dacdat,
  output logic                o_underrun,
  output logic [UCNT_W-1:0]   o_ucount
);

  localparam int CW = $clog2(SAMPLE_W + 1);

  logic                lrck_q, lrck_d;
  logic                synced_q, synced_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;
  logic                mode_q, mode_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dacdat_q, dacdat_d;
  logic                underrun_q, underrun_d;
  logic [UCNT_W-1:0]   ucount_q, ucount_d;

  logic                left_start, right_start, start, mode_eff;
  logic [SAMPLE_W-1:0] word;

  always_comb begin
    lrck_d      = i_daclrck;
    synced_d    = synced_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    frm_l_d     = frm_l_q;
    frm_r_d     = frm_r_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    dacdat_d    = 1'b0;
    underrun_d  = 1'b0;
    ucount_d    = ucount_q;
    start       = 1'b0;
    mode_eff    = mode_q;
    word        = '0;

    left_start  = lrck_q & ~i_daclrck;
    right_start = ~lrck_q & i_daclrck;

    if (i_valid && !hold_full_q) begin
      hold_l_d    = i_left;
      hold_r_d    = i_right;
      hold_full_d = 1'b1;
    end

    // A left start is always honoured: it is what brings the serializer into sync.
    if (left_start) begin
      synced_d = 1'b1;
      start    = 1'b1;
      if (hold_full_q) begin
        frm_l_d     = hold_l_q;
        frm_r_d     = hold_r_q;
        hold_full_d = 1'b0;
        mode_d      = i_mode;
        mode_eff    = i_mode;
        word        = hold_l_q;
      end else begin
        frm_l_d    = '0;
        frm_r_d    = '0;
        underrun_d = 1'b1;
        if (ucount_q != {UCNT_W{1'b1}}) ucount_d = ucount_q + UCNT_W'(1);
      end
    end else if (right_start && synced_q) begin
      start = 1'b1;
      word  = frm_r_q;
    end

    // Left-justified puts the MSB out on the start edge; I2S spends that edge on a zero.
    if (start) begin
      if (mode_eff) begin
        dacdat_d = word[SAMPLE_W-1];
        shift_d  = word << 1;
        cnt_d    = CW'(SAMPLE_W - 1);
      end else begin
        shift_d  = word;
        cnt_d    = CW'(SAMPLE_W);
      end
    end else if (cnt_q != '0) begin
      dacdat_d = shift_q[SAMPLE_W-1];
      shift_d  = shift_q << 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_q      <= 1'b0;
      synced_q    <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      frm_l_q     <= '0;
      frm_r_q     <= '0;
      mode_q      <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
      ucount_q    <= '0;
    end else begin
      lrck_q      <= lrck_d;
      synced_q    <= synced_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      frm_l_q     <= frm_l_d;
      frm_r_q     <= frm_r_d;
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
      ucount_q    <= ucount_d;
    end
  end

  assign o_ready    = ~hold_full_q;
  assign o_dacdat   = dacdat_q;
  assign o_underrun = underrun_q;
  assign o_ucount   = ucount_q;

endmodule

// File: tb/tb_play_i2s_tx.sv
// tb/tb_play_i2s_tx.sv - directed frame-level bench for play_i2s_tx (SAMPLE_W=16, UCNT_W=8).
module tb_play_i2s_tx;

  logic        bclk = 1'b1;
  logic        rst_n = 1'b0;
  logic        daclrck = 1'b1;
  logic        mode = 1'b0;
  logic [15:0] left = '0, right = '0;
  logic        valid = 1'b0;
  logic        ready, dacdat, underrun;
  logic [7:0]  ucount;

  int checks = 0;
  int errors = 0;
  logic [31:0] src_q[$];

  typedef struct {
    logic        push;
    logic [15:0] pl, pr;
    logic        md;
    int          hl;
    int          d;
    logic        eu;
    logic [7:0]  eucnt;
  } row_t;
  row_t rows[5];

  play_i2s_tx #(.SAMPLE_W(16), .UCNT_W(8)) dut (
    .i_bclk(bclk), .i_rst_n(rst_n), .i_daclrck(daclrck), .i_mode(mode),
    .i_left(left), .i_right(right), .i_valid(valid), .o_ready(ready),
    .o_dacdat(dacdat), .o_underrun(underrun), .o_ucount(ucount)
  );

  always #5 bclk = ~bclk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic expbit(input logic [15:0] w, input int t, input int d);
    if (t < d) return 1'b0;
    if (t - d < 16) return w[15-(t-d)];
    return 1'b0;
  endfunction

  // One falling edge: drive at posedge, let the falling edge pass, return at the next posedge.
  task automatic cyc(input logic lr);
    logic acc;
    daclrck = lr;
    if (src_q.size() > 0) begin
      valid = 1'b1;
      {left, right} = src_q[0];
    end else begin
      valid = 1'b0;
    end
    acc = valid && ready;
    @(posedge bclk);
    if (acc) void'(src_q.pop_front());
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    src_q.push_back({l, r});
  endtask

  task automatic idle_r(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      check("idle_dacdat", dacdat, 1'b0);
      check("idle_underrun", underrun, 1'b0);
    end
  endtask

  task automatic frame(input int hl, input logic [15:0] el, input logic [15:0] er,
                       input int d, input logic eu, input logic mid_mode);
    for (int h = 0; h < 2; h++) begin
      if (h == 1) mode = mid_mode;
      for (int t = 0; t < hl; t++) begin
        cyc(h == 1);
        check("dacdat", dacdat, expbit((h == 1) ? er : el, t, d));
        if (h == 0 && t < 2) check("underrun", underrun, (t == 0) ? eu : 1'b0);
      end
    end
  endtask

  initial begin
    rows[0] = '{1'b1, 16'hA5C3, 16'h8001, 1'b0, 32, 1, 1'b0, 8'd0};
    rows[1] = '{1'b1, 16'hA5C3, 16'h8001, 1'b1, 32, 0, 1'b0, 8'd0};
    rows[2] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 32, 0, 1'b1, 8'd1};
    rows[3] = '{1'b1, 16'h0001, 16'hFFFE, 1'b0, 17, 1, 1'b0, 8'd1};
    rows[4] = '{1'b1, 16'h8000, 16'h7FFF, 1'b1, 16, 0, 1'b0, 8'd1};

    repeat (3) @(posedge bclk);
    check("rst_dacdat", dacdat, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ucount", ucount, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      mode = rows[i].md;
      if (rows[i].push) begin
        push(rows[i].pl, rows[i].pr);
        idle_r(2);
        check("ready_after_accept", ready, 1'b0);
      end
      frame(rows[i].hl, rows[i].push ? rows[i].pl : 16'h0000,
            rows[i].push ? rows[i].pr : 16'h0000, rows[i].d, rows[i].eu, rows[i].md);
      check("row_ucount", ucount, rows[i].eucnt);
    end

    for (int i = 0; i < 300; i++) frame(2, 16'h0, 16'h0, 0, 1'b1, mode);
    check("ucount_saturated", ucount, 8'hFF);

    // Backpressure: P1 lands on an underrunning left start, P2 waits a full frame.
    mode = 1'b0;
    push(16'h1234, 16'h5678);
    push(16'h9ABC, 16'hDEF0);
    frame(32, 16'h0, 16'h0, 1, 1'b1, 1'b0);
    check("bp_pending", src_q.size(), 1);
    check("bp_ready_low", ready, 1'b0);
    frame(32, 16'h1234, 16'h5678, 1, 1'b0, 1'b0);
    check("bp_p2_taken", src_q.size(), 0);
    frame(32, 16'h9ABC, 16'hDEF0, 1, 1'b0, 1'b0);
    check("bp_ucount_hold", ucount, 8'hFF);

    // Truncation: 8 bclk halves, I2S.
    push(16'hFFFF, 16'hFFFF);
    push(16'hFFFF, 16'hFFFF);
    idle_r(2);
    frame(8, 16'hFFFF, 16'hFFFF, 1, 1'b0, 1'b0);
    frame(8, 16'hFFFF, 16'hFFFF, 1, 1'b0, 1'b0);
    frame(32, 16'h0, 16'h0, 1, 1'b1, 1'b0);

    // Reset in the middle of a left word.
    push(16'hC3C3, 16'h3C3C);
    push(16'h5555, 16'hAAAA);
    idle_r(2);
    for (int t = 0; t < 5; t++) begin
      cyc(1'b0);
      check("pre_rst_dacdat", dacdat, expbit(16'hC3C3, t, 1));
    end
    check("pre_rst_ready", ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dacdat", dacdat, 1'b0);
    check("async_rst_ready", ready, 1'b1);
    check("async_rst_ucount", ucount, 8'd0);
    src_q.delete();
    valid = 1'b0;
    @(posedge bclk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      cyc(1'b0);
      check("unsynced_dacdat", dacdat, 1'b0);
    end
    mode = 1'b1;
    push(16'h1111, 16'hEEEE);
    idle_r(32);
    frame(32, 16'h1111, 16'hEEEE, 0, 1'b0, 1'b0);
    check("resync_ucount", ucount, 8'd0);
    push(16'h2222, 16'hDDDD);
    idle_r(2);
    frame(32, 16'h2222, 16'hDDDD, 1, 1'b0, 1'b0);
    check("final_ucount", ucount, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
